// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI master
package spi_pkg;
    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_t;
    localparam int DEF_CLK_DIV = 4;
    localparam int DATA_W = 8;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick every CLK_DIV enabled cycles, marking SCLK half-periods
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    logic [7:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    // count 0..CLK_DIV-1 while enabled, restarting at each tick or on clear
    always_ff @(posedge clk) begin
        if (rst || i_clr || !i_en || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 8'd1;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 MSB-first byte SPI master; SPI_MASTER_LOOPBACK_EN feeds mosi back into rx
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_send,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss
);
    state_t r_state, w_state;
    logic [DATA_W-1:0] r_tx, w_tx, r_rx, w_rx, r_dout, w_dout;
    logic [2:0] r_bit, w_bit;
    logic r_sclk, w_sclk, r_ss, w_ss, r_busy, w_busy;
    logic w_tick, w_accept, w_sample;

    assign w_accept = (r_state == IDLE) && !r_busy && ready_send;
`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sample = r_tx[DATA_W-1];
`else
    assign w_sample = miso;
`endif

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != IDLE),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    // next-state and next-output logic; mosi is always the tx MSB, which is zero once all bits are shifted out
    always_comb begin
        w_state = r_state;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_dout  = r_dout;
        w_bit   = r_bit;
        w_sclk  = r_sclk;
        w_ss    = r_ss;
        w_busy  = r_busy;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state = LEAD;
                    w_tx    = data_in;
                    w_ss    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            LEAD: begin
                if (w_tick)
                    w_state = SHIFT;
            end
            SHIFT: begin
                if (w_tick) begin
                    w_sclk = !r_sclk;
                    if (!r_sclk)
                        w_rx = {r_rx[DATA_W-2:0], w_sample};
                    else begin
                        w_tx  = {r_tx[DATA_W-2:0], 1'b0};
                        w_bit = r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            w_state = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (w_tick) begin
                    w_state = IDLE;
                    w_ss    = 1'b1;
                    w_busy  = 1'b0;
                    w_dout  = r_rx;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // register state and every SPI-facing output so the pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_ss    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_dout  <= w_dout;
            r_bit   <= w_bit;
            r_sclk  <= w_sclk;
            r_ss    <= w_ss;
            r_busy  <= w_busy;
        end
    end

    assign busy     = r_busy;
    assign data_out = r_dout;
    assign sclk     = r_sclk;
    assign mosi     = r_tx[DATA_W-1];
    assign ss       = r_ss;
endmodule
